// File: rtl/hd44780_responder.sv
// Display-side model of the HD44780 8-bit write interface: decodes strobed writes into an
// 80-byte DDRAM, address counter and mode registers, with emulated busy timing.
module hd44780_responder #(
  parameter int unsigned CMD_CYCLES   = 20,
  parameter int unsigned CLEAR_CYCLES = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic       rs,
  input  logic [7:0] db,
  input  logic [6:0] raddr,
  output logic [7:0] rdata,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_id,
  output logic       entry_s,
  output logic       fs_dl,
  output logic       fs_n,
  output logic       fs_f,
  output logic [5:0] shift_off,
  output logic       err
);

  localparam int unsigned MaxCycles = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [1:0] {StInitFill, StIdle, StBusy, StFill} state_e;

  state_e          state;
  logic            e_q, rs_l, sel_cg;
  logic [7:0]      db_l;
  logic [6:0]      fcnt;
  logic [CntW-1:0] bcnt;
  logic [7:0]      mem [80];
  logic            wr;
  logic [7:0]      map;
  logic            mem_we;
  logic [6:0]      mem_addr;
  logic [7:0]      mem_wdata;

  // Returns {valid, linear index} for a DDRAM address under the current line mode.
  function automatic logic [7:0] ddram_map(input logic [6:0] a, input logic n);
    if (n) begin
      if (a <= 7'h27) return {1'b1, a};
      if (a >= 7'h40 && a <= 7'h67) return {1'b1, a - 7'd24};
      return 8'h00;
    end
    if (a <= 7'h4f) return {1'b1, a};
    return 8'h00;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up, input logic cg,
                                         input logic n);
    if (cg) return up ? {1'b0, a[5:0] + 6'd1} : {1'b0, a[5:0] - 6'd1};
    if (n) begin
      if (up) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      return (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
    end
    if (up) return (a == 7'h4f) ? 7'h00 : a + 7'd1;
    return (a == 7'h00) ? 7'h4f : a - 7'd1;
  endfunction

  function automatic logic [5:0] so_step(input logic [5:0] so, input logic up);
    if (up) return (so == 6'd39) ? 6'd0 : so + 6'd1;
    return (so == 6'd0) ? 6'd39 : so - 6'd1;
  endfunction

  assign wr  = ~e & e_q;
  assign map = ddram_map(ac, fs_n);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = fcnt;
    mem_wdata = 8'h20;
    if (state == StInitFill || state == StFill) begin
      mem_we = 1'b1;
    end else if (wr && !busy && rs_l && !sel_cg && map[7]) begin
      mem_we    = 1'b1;
      mem_addr  = map[6:0];
      mem_wdata = db_l;
    end
  end

  // DDRAM has no reset; INIT_FILL rewrites it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StInitFill;
      busy      <= 1'b1;
      e_q       <= 1'b0;
      rs_l      <= 1'b0;
      db_l      <= 8'h00;
      sel_cg    <= 1'b0;
      fcnt      <= 7'd0;
      bcnt      <= '0;
      rdata     <= 8'h00;
      ac        <= 7'd0;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      entry_id  <= 1'b1;
      entry_s   <= 1'b0;
      fs_dl     <= 1'b1;
      fs_n      <= 1'b0;
      fs_f      <= 1'b0;
      shift_off <= 6'd0;
      err       <= 1'b0;
    end else begin
      e_q <= e;
      if (e) begin
        rs_l <= rs;
        db_l <= db;
      end
      rdata <= (raddr < 7'd80) ? mem[raddr] : 8'h00;

      unique case (state)
        StInitFill: begin
          fcnt <= fcnt + 7'd1;
          if (fcnt == 7'd79) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        StFill: begin
          fcnt <= fcnt + 7'd1;
          bcnt <= bcnt - 1'b1;
          if (fcnt == 7'd79) state <= StBusy;
        end
        StBusy: begin
          if (bcnt == '0) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            bcnt <= bcnt - 1'b1;
          end
        end
        default: ;
      endcase

      if (wr) begin
        if (busy) begin
          err <= 1'b1;
        end else if (rs_l || db_l != 8'h00) begin
          busy  <= 1'b1;
          state <= StBusy;
          bcnt  <= CntW'(CMD_CYCLES - 1);
          if (rs_l) begin
            if (!sel_cg && !map[7]) err <= 1'b1;
            ac <= ac_step(ac, entry_id, sel_cg, fs_n);
            if (entry_s) shift_off <= so_step(shift_off, entry_id);
          end else begin
            priority casez (db_l)
              8'b1???????: begin
                sel_cg <= 1'b0;
                ac     <= db_l[6:0];
              end
              8'b01??????: begin
                sel_cg <= 1'b1;
                ac     <= {1'b0, db_l[5:0]};
              end
              8'b001?????: begin
                fs_dl <= db_l[4];
                fs_n  <= db_l[3];
                fs_f  <= db_l[2];
              end
              8'b0001????: begin
                if (db_l[3]) shift_off <= so_step(shift_off, db_l[2]);
                else         ac        <= ac_step(ac, db_l[2], sel_cg, fs_n);
              end
              8'b00001???: begin
                disp_on   <= db_l[2];
                cursor_on <= db_l[1];
                blink_on  <= db_l[0];
              end
              8'b000001??: begin
                entry_id <= db_l[1];
                entry_s  <= db_l[0];
              end
              8'b0000001?: begin
                ac        <= 7'd0;
                shift_off <= 6'd0;
                sel_cg    <= 1'b0;
                bcnt      <= CntW'(CLEAR_CYCLES - 1);
              end
              default: begin
                // Clear: busy count spans the 80-cycle fill plus the remaining wait.
                ac        <= 7'd0;
                entry_id  <= 1'b1;
                shift_off <= 6'd0;
                sel_cg    <= 1'b0;
                fcnt      <= 7'd0;
                state     <= StFill;
                bcnt      <= CntW'(CLEAR_CYCLES - 1);
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hd44780_responder.sv
// Randomized self-checking bench for hd44780_responder against a linear-index DDRAM model.
module tb_hd44780_responder;
  localparam int CMD = 20;
  localparam int CLR = 2500;

  logic       clk = 1'b0, rst = 1'b0, e = 1'b0, rs = 1'b0;
  logic [7:0] db = 8'h00;
  logic [6:0] raddr = 7'd0;
  logic [7:0] rdata;
  logic       busy, disp_on, cursor_on, blink_on, entry_id, entry_s, fs_dl, fs_n, fs_f, err;
  logic [6:0] ac;
  logic [5:0] shift_off;

  always #5 clk = ~clk;

  hd44780_responder #(.CMD_CYCLES(CMD), .CLEAR_CYCLES(CLR)) dut (
    .clk(clk), .rst(rst), .e(e), .rs(rs), .db(db), .raddr(raddr), .rdata(rdata), .busy(busy),
    .ac(ac), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .entry_id(entry_id), .entry_s(entry_s), .fs_dl(fs_dl), .fs_n(fs_n), .fs_f(fs_f),
    .shift_off(shift_off), .err(err)
  );

  int n_cmp = 0, n_bad = 0;

  logic [7:0] m_mem [80];
  int m_ac, m_so;
  bit m_cg, m_id, m_s, m_d, m_c, m_b, m_dl, m_n, m_f, m_err;

  wire [21:0] dut_state = {ac, disp_on, cursor_on, blink_on, entry_id, entry_s, fs_dl, fs_n,
                           fs_f, shift_off, err};

  function automatic logic [21:0] m_state();
    return {7'(m_ac), m_d, m_c, m_b, m_id, m_s, m_dl, m_n, m_f, 6'(m_so), m_err};
  endfunction

  // Address -> linear screen index, -1 if the address has no cell.
  function automatic int lin(int a, bit n);
    if (n) begin
      if (a < 40) return a;
      if (a >= 64 && a < 104) return a - 24;
      return -1;
    end
    return (a < 80) ? a : -1;
  endfunction

  function automatic int unlin(int i, bit n);
    return (n && i >= 40) ? i + 24 : i;
  endfunction

  function automatic int step(int a, bit up, bit cg, bit n);
    int i;
    if (cg) return (a + (up ? 1 : 63)) % 64;
    i = lin(a, n);
    if (i >= 0) return unlin((i + (up ? 1 : 79)) % 80, n);
    return (a + (up ? 1 : 127)) % 128;
  endfunction

  function automatic void m_reset();
    m_ac = 0; m_so = 0; m_cg = 0; m_id = 1; m_s = 0; m_d = 0; m_c = 0; m_b = 0;
    m_dl = 1; m_n = 0; m_f = 0; m_err = 0;
    for (int k = 0; k < 80; k++) m_mem[k] = 8'h20;
  endfunction

  // Applies one accepted write; returns the expected busy length.
  function automatic int m_apply(bit r, logic [7:0] d);
    int i;
    if (r) begin
      i = lin(m_ac, m_n);
      if (!m_cg) begin
        if (i >= 0) m_mem[i] = d;
        else m_err = 1;
      end
      m_ac = step(m_ac, m_id, m_cg, m_n);
      if (m_s) m_so = (m_so + (m_id ? 1 : 39)) % 40;
      return CMD;
    end
    if (d[7]) begin m_cg = 0; m_ac = int'(d[6:0]); end
    else if (d[6]) begin m_cg = 1; m_ac = int'(d[5:0]); end
    else if (d[5]) begin m_dl = d[4]; m_n = d[3]; m_f = d[2]; end
    else if (d[4]) begin
      if (d[3]) m_so = (m_so + (d[2] ? 1 : 39)) % 40;
      else m_ac = step(m_ac, d[2], m_cg, m_n);
    end
    else if (d[3]) begin m_d = d[2]; m_c = d[1]; m_b = d[0]; end
    else if (d[2]) begin m_id = d[1]; m_s = d[0]; end
    else if (d[1]) begin m_ac = 0; m_so = 0; m_cg = 0; return CLR; end
    else if (d[0]) begin
      m_ac = 0; m_id = 1; m_so = 0; m_cg = 0;
      for (int k = 0; k < 80; k++) m_mem[k] = 8'h20;
      return CLR;
    end
    else return 0;
    return CMD;
  endfunction

  // Starts and ends at a negedge; the write is detected on the posedge just before return.
  task automatic strobe(input bit r, input logic [7:0] d, input int hold);
    e = 1'b1; rs = r; db = d;
    repeat (hold) @(negedge clk);
    e = 1'b0; rs = ~r; db = ~d;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max, output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < max) begin
      cnt++;
      @(negedge clk);
    end
    if (busy !== 1'b0) cnt = -1;
  endtask

  task automatic read_cell(input int idx, output logic [7:0] v);
    raddr = 7'(idx);
    @(negedge clk);
    v = rdata;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, rdata, dut_state} !== {1'b1, 8'h00, m_state()})
      $display("FAIL reset: got %h want %h", {busy, rdata, dut_state}, {1'b1, 8'h00, m_state()});
  endtask

  task automatic test_init_fill();
    int cnt;
    logic [7:0] v;
    rst = 1'b1;
    wait_idle(200, cnt);
    n_cmp++;
    if (cnt !== 80) begin n_bad++; $display("FAIL init_busy: got %0d want 80", cnt); end
    for (int i = 0; i < 80; i++) begin
      read_cell(i, v);
      n_cmp++;
      if (v !== m_mem[i]) begin n_bad++; $display("FAIL init_cell%0d: got %h want %h", i, v, m_mem[i]); end
    end
  endtask

  task automatic test_config();
    logic [7:0] ops [3];
    int cnt, exp;
    ops = '{8'h38, 8'h0e, 8'h06};
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0, ops[i], 5);
      exp = m_apply(1'b0, ops[i]);
      wait_idle(CLR + 10, cnt);
      n_cmp++;
      if (cnt !== exp) begin n_bad++; $display("FAIL config_busy%0d: got %0d want %0d", i, cnt, exp); end
      repeat (3) @(negedge clk);
    end
    n_cmp++;
    if ({fs_n, disp_on, cursor_on, blink_on, entry_id, entry_s, err} !== 7'b1110100) begin
      n_bad++;
      $display("FAIL config_flags: got %b want 1110100",
               {fs_n, disp_on, cursor_on, blink_on, entry_id, entry_s, err});
    end
    n_cmp++;
    if (dut_state !== m_state()) begin n_bad++; $display("FAIL config_state: got %h want %h", dut_state, m_state()); end
  endtask

  // Runs a short list of writes, checking each busy length.
  task automatic run_ops(input string name, input bit r [], input logic [7:0] d []);
    int cnt, exp;
    for (int i = 0; i < r.size(); i++) begin
      strobe(r[i], d[i], $urandom_range(1, 5));
      exp = m_apply(r[i], d[i]);
      wait_idle(CLR + 10, cnt);
      n_cmp++;
      if (cnt !== exp) begin n_bad++; $display("FAIL %s_busy%0d: got %0d want %0d", name, i, cnt, exp); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_data();
    logic [7:0] v0, v1;
    run_ops("data", '{1'b0, 1'b1, 1'b1}, '{8'h94, 8'h41, 8'h42});
    read_cell(20, v0);
    read_cell(21, v1);
    n_cmp++;
    if ({v0, v1, ac} !== {8'h41, 8'h42, 7'h16})
      begin n_bad++; $display("FAIL data: got %h want %h", {v0, v1, ac}, {8'h41, 8'h42, 7'h16}); end
  endtask

  task automatic test_wrap();
    logic [7:0] a, b, v0, v1;
    a = 8'($urandom); b = 8'($urandom);
    run_ops("wrap", '{1'b0, 1'b1, 1'b1}, '{8'ha7, a, b});
    read_cell(39, v0);
    read_cell(40, v1);
    n_cmp++;
    if ({v0, v1, ac} !== {a, b, 7'h41})
      begin n_bad++; $display("FAIL wrap: got %h want %h", {v0, v1, ac}, {a, b, 7'h41}); end
  endtask

  task automatic test_busy_violation();
    int cnt;
    logic [7:0] v;
    strobe(1'b1, 8'h5a, 1);
    void'(m_apply(1'b1, 8'h5a));
    repeat (2) @(negedge clk);
    strobe(1'b1, 8'ha5, 1);
    m_err = 1;
    n_cmp++;
    if ({busy, err} !== 2'b11) begin n_bad++; $display("FAIL viol_flags: got %b want 11", {busy, err}); end
    wait_idle(CLR + 10, cnt);
    n_cmp++;
    if (cnt !== CMD - 4) begin n_bad++; $display("FAIL viol_busy: got %0d want %0d", cnt, CMD - 4); end
    n_cmp++;
    if (dut_state !== m_state()) begin n_bad++; $display("FAIL viol_state: got %h want %h", dut_state, m_state()); end
    for (int i = 0; i < 80; i++) begin
      read_cell(i, v);
      n_cmp++;
      if (v !== m_mem[i]) begin n_bad++; $display("FAIL viol_cell%0d: got %h want %h", i, v, m_mem[i]); end
    end
  endtask

  task automatic test_random();
    int cnt, exp, kind;
    bit r;
    logic [7:0] d, v;
    for (int n = 0; n < 60; n++) begin
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (!r) begin
        kind = $urandom_range(0, 6);
        case (kind)
          0: d = 8'h80 | (d & 8'h7f);
          1: d = 8'h40 | (d & 8'h3f);
          2: d = 8'h20 | (d & 8'h1f);
          3: d = 8'h10 | (d & 8'h0f);
          4: d = 8'h08 | (d & 8'h07);
          5: d = 8'h04 | (d & 8'h03);
          default: d = 8'h00;
        endcase
      end
      strobe(r, d, $urandom_range(1, 4));
      exp = m_apply(r, d);
      wait_idle(CLR + 10, cnt);
      n_cmp++;
      if (cnt !== exp) begin n_bad++; $display("FAIL rand_busy%0d: got %0d want %0d", n, cnt, exp); end
      n_cmp++;
      if (dut_state !== m_state())
        begin n_bad++; $display("FAIL rand_state%0d: got %h want %h (rs=%0d db=%h)", n, dut_state, m_state(), r, d); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 80; i++) begin
      read_cell(i, v);
      n_cmp++;
      if (v !== m_mem[i]) begin n_bad++; $display("FAIL rand_cell%0d: got %h want %h", i, v, m_mem[i]); end
    end
  endtask

  task automatic test_clear_home();
    int cnt, exp;
    logic [7:0] v;
    run_ops("fill", '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
            '{8'h38, 8'h80 | 8'($urandom_range(0, 30)), 8'h11, 8'h22, 8'h33});
    strobe(1'b0, 8'h01, 2);
    exp = m_apply(1'b0, 8'h01);
    wait_idle(CLR + 10, cnt);
    n_cmp++;
    if (cnt !== CLR || exp !== CLR) begin n_bad++; $display("FAIL clear_busy: got %0d want %0d", cnt, CLR); end
    n_cmp++;
    if (dut_state !== m_state() || ac !== 7'd0)
      begin n_bad++; $display("FAIL clear_state: got %h want %h", dut_state, m_state()); end
    for (int i = 0; i < 80; i++) begin
      read_cell(i, v);
      n_cmp++;
      if (v !== 8'h20) begin n_bad++; $display("FAIL clear_cell%0d: got %h want 20", i, v); end
    end
    run_ops("home_pre", '{1'b0, 1'b0, 1'b1}, '{8'h07, 8'h80 | 8'($urandom_range(0, 30)), 8'h44});
    strobe(1'b0, 8'h02, 1);
    exp = m_apply(1'b0, 8'h02);
    wait_idle(CLR + 10, cnt);
    n_cmp++;
    if (cnt !== exp) begin n_bad++; $display("FAIL home_busy: got %0d want %0d", cnt, exp); end
    n_cmp++;
    if (dut_state !== m_state()) begin n_bad++; $display("FAIL home_state: got %h want %h", dut_state, m_state()); end
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    logic [7:0] v;
    run_ops("rst_pre", '{1'b0, 1'b1}, '{8'h85, 8'h77});
    strobe(1'b0, 8'h01, 1);
    repeat (30) @(negedge clk);
    rst = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, dut_state} !== {1'b1, m_state()})
      begin n_bad++; $display("FAIL rst_mid_state: got %h want %h", {busy, dut_state}, {1'b1, m_state()}); end
    rst = 1'b1;
    wait_idle(200, cnt);
    n_cmp++;
    if (cnt !== 80) begin n_bad++; $display("FAIL rst_mid_busy: got %0d want 80", cnt); end
    for (int i = 0; i < 80; i++) begin
      read_cell(i, v);
      n_cmp++;
      if (v !== 8'h20) begin n_bad++; $display("FAIL rst_mid_cell%0d: got %h want 20", i, v); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    if (n_bad == 0 && !({busy, rdata, dut_state} === {1'b1, 8'h00, m_state()})) n_bad++;
    test_init_fill();
    test_config();
    test_data();
    test_wrap();
    test_busy_violation();
    test_random();
    test_clear_home();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hd44780_responder.md
# hd44780_responder

Synthesizable model of the display side of the 8-bit HD44780 write interface. It samples `e`/`rs`/`db` driven by the team's 8-bit controller and decodes instructions and data writes into an 80-byte DDRAM, an address counter and mode registers. It emulates busy timing and flags protocol violations. It sits opposite the controller in loopback benches and FPGA self-test builds, where a host reads the DDRAM contents back through a side port.

## Interface
- `CMD_CYCLES`, default 20: busy length for every instruction and data write except clear and home (80 µs at 250 kHz).
- `CLEAR_CYCLES`, default 2500: busy length for clear and home (10 ms). Must be ≥ 81.
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset. Asynchronous, active-low.
- `e` input, 1 bit: enable strobe.
- `rs` input, 1 bit: register select. 0 = instruction, 1 = data.
- `db` input, 8 bits: data bus.
- `raddr` input, 7 bits: linear DDRAM read index, 0–79.
- `rdata` output, 8 bits: DDRAM[`raddr`], registered with 1-cycle latency.
- `busy` output, 1 bit: emulated busy flag.
- `ac` output, 7 bits: address counter.
- `disp_on`, `cursor_on`, `blink_on` outputs, 1 bit each: D, C and B bits of display control.
- `entry_id`, `entry_s` outputs, 1 bit each: entry-mode bits.
- `fs_dl`, `fs_n`, `fs_f` outputs, 1 bit each: function-set bits.
- `shift_off` output, 6 bits: display shift offset, 0–39.
- `err` output, 1 bit: sticky protocol-error flag.

## Operation
- Strobe capture:
  - `e_q` holds `e` from the previous cycle.
  - While `e`=1, `rs_l`/`db_l` load `rs`/`db` every cycle.
  - A write is detected on any edge where `e`=0 and `e_q`=1; it uses `rs_l`/`db_l`.
- States:
  - INIT_FILL: after reset.
  - IDLE.
  - BUSY: down-counter `bcnt`.
  - FILL: clear in progress.
- INIT_FILL:
  - Writes 0x20 to index 0..79, one per cycle, with `busy`=1.
  - Then goes to IDLE.
- Write detected while `busy`=1: dropped, and `err` is set to 1.
- Instruction decode (`rs`=0), highest set bit wins:
  - `1xxxxxxx`: AC ← db[6:0], selects DDRAM.
  - `01xxxxxx`: selects CGRAM; AC ← db[5:0].
  - `001DNFxx`: function set.
  - `0001SRxx`: shift. S=1 shifts the display; S=0 moves AC as with I/D=R.
  - `00001DCB`: display control.
  - `000001IS`: entry mode.
  - `0000001x`: home. AC=0, `shift_off`=0.
  - `00000001`: clear. AC=0, `entry_id`=1, `shift_off`=0, then FILL. Count runs from start of fill.
  - `00000000`: ignored, no busy.
- Data write (`rs`=1):
  - With DDRAM selected and AC valid: DDRAM[idx(AC)] ← db.
  - With CGRAM selected: data discarded.
  - Then AC steps by +1 if `entry_id`=1, otherwise −1.
  - If `entry_s`=1, `shift_off` steps the same direction, modulo 40.
- Address mapping:
  - `fs_n`=1: 0x00–0x27 map to idx 0–39; 0x40–0x67 map to idx 40–79.
    - Increment wraps 0x27→0x40 and 0x67→0x00; decrement is the exact reverse.
  - `fs_n`=0: 0x00–0x4F map to idx 0–79, wrapping 0x4F↔0x00.
  - CGRAM AC wraps modulo 64.
  - Set-DDRAM to an unmapped address: AC loads as given, data writes there are dropped, `err`=1, AC still steps.

## Timing
- Reset values:
  - State INIT_FILL, `busy`=1.
  - `ac`=0, `disp_on`=`cursor_on`=`blink_on`=0.
  - `entry_id`=1, `entry_s`=0.
  - `fs_dl`=1, `fs_n`=0, `fs_f`=0.
  - `shift_off`=0, `err`=0, `rdata`=0.
- The detecting edge executes the write and raises `busy` on that same edge.
- `busy` stays high for exactly `CMD_CYCLES`, or `CLEAR_CYCLES` for clear and home. It then falls, and a new write may be detected on the very next edge.
- Clear:
  - Cycles 1–80 of busy fill idx 0–79 with 0x20.
  - `busy` falls after `CLEAR_CYCLES`.
- Asserting reset mid-operation aborts everything and restarts INIT_FILL. DDRAM is not reset asynchronously.
- `e` pulses shorter than 1 cycle are not guaranteed to be detected. Glitch-free `e`, ≥1 cycle high, is required.

## Test plan
- Reset, then wait 80 cycles: `busy` falls at cycle 81, and `raddr` 0..79 read 0x20.
- Send 0x38, 0x0E, 0x06, each 5 cycles high with 2500-cycle gaps:
  - `fs_n`=1, `disp_on`=1, `cursor_on`=1, `blink_on`=0, `entry_id`=1, `entry_s`=0, `err`=0.
- Send 0x94, then data 'A' (0x41) 'B' (0x42) with 30-cycle gaps:
  - idx 20=0x41, idx 21=0x42, `ac`=0x16.
- Send 0xA7, then two data writes:
  - idx 39 written, AC wraps to 0x40, idx 40 written, `ac`=0x41.
- Send a data write 3 cycles after the previous strobe:
  - The write is dropped, `err`=1, and DDRAM is unchanged.
- Fill several cells, then send 0x01:
  - `busy`=1 for 2500 cycles, all cells 0x20, `ac`=0.
- Pulse `rst` mid-clear: INIT_FILL restarts and `busy` falls after 80 cycles.
